fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch for the lanzones core.
// Issues word reads on the RRdy/RAddr bus, buffers returned words with their
// byte pc in a small FIFO, and hands {pc, instruction} to decode. Redirects
// flush the buffer and discard any response still in flight.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | after reset, waiting for start; no requests
// S_FETCH | request issued or in flight (or dropping a stale response)
// S_WAIT  | buffer full, nothing in flight; resumes on the next pop
// S_HALT  | fetching stopped until reset; buffer still drains to decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        halt,
    input  logic        redir_vld,
    input  logic [31:0] redir_pc,
    output logic        RRdy,
    output logic [31:0] RAddr,
    input  logic        RVld,
    input  logic [31:0] RData,
    output logic        inst_vld,
    input  logic        inst_rdy,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HALT} state_t;

    state_t           state_q;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      raddr_q;
    logic             rrdy_q;
    logic             drop_q;
    logic             halt_pend_q;

    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic active, outstanding, still_out, redir, halt_now;
    logic push, pop, flush;

    // Per-cycle decisions: what the response, redirect and decode do to the buffer and pc.
    always_comb begin
        active      = (state_q == S_FETCH) || (state_q == S_WAIT);
        // rrdy_q high means memory has sampled (or is sampling) the request
        outstanding = rrdy_q || drop_q;
        still_out   = outstanding && !RVld;
        // once a halt is pending, the stream is frozen and redirects no longer apply
        redir       = active && redir_vld && !halt_pend_q;
        halt_now    = active && (halt || halt_pend_q);
        flush       = redir;
        push        = active && outstanding && RVld && !drop_q && !redir;
        pop         = inst_vld && inst_rdy && !flush;
        count_d     = flush ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));

        pc_d = pc_q;
        if ((state_q == S_IDLE) && start) begin
            pc_d = RESET_PC;
        end else if (redir) begin
            pc_d = redir_pc & 32'hFFFF_FFFC;
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Fetch sequencer: request issue, stale-response drop and halt handling.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            raddr_q     <= '0;
            rrdy_q      <= 1'b0;
            drop_q      <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if ((state_q != S_IDLE) || start) begin
                raddr_q <= {2'b00, pc_d[31:2]};
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        rrdy_q  <= 1'b1;
                    end
                end
                S_FETCH, S_WAIT: begin
                    if (halt) begin
                        halt_pend_q <= 1'b1;
                    end
                    if (still_out) begin
                        // keep the bus request steady until the response shows up
                        state_q <= S_FETCH;
                        if (redir) begin
                            drop_q <= 1'b1;
                            rrdy_q <= 1'b0;
                        end
                    end else begin
                        drop_q <= 1'b0;
                        if (halt_now) begin
                            rrdy_q  <= 1'b0;
                            state_q <= S_HALT;
                        end else if (count_d < FULL_CNT) begin
                            rrdy_q  <= 1'b1;
                            state_q <= S_FETCH;
                        end else begin
                            rrdy_q  <= 1'b0;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_HALT: begin
                    rrdy_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    rrdy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Instruction buffer: pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            count_q <= count_d;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    fifo_data_q[wr_ptr_q] <= RData;
                    fifo_pc_q[wr_ptr_q]   <= pc_q;
                    wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    assign RRdy      = rrdy_q;
    assign RAddr     = raddr_q;
    assign inst_vld  = (count_q != '0);
    assign inst_data = fifo_data_q[rd_ptr_q];
    assign inst_pc   = fifo_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tests for fetch_unit against a word-addressed memory
// responder and a stream-level model of the instructions decode must see.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        redir_vld = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        inst_rdy = 1'b0;
    logic        RRdy;
    logic [31:0] RAddr;
    logic        inst_vld;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    logic        mem_rvld = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0;
    int          mem_lat = 1;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [31:0] req_log[$];
    logic [31:0] pop_pc_log[$];
    logic [31:0] pop_data_log[$];
    int          pop_cyc_log[$];

    typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;
    mode_t       mode = M_IDLE;
    logic [31:0] exp_pc = '0;

    fetch_unit dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .halt      (halt),
        .redir_vld (redir_vld),
        .redir_pc  (redir_pc),
        .RRdy      (RRdy),
        .RAddr     (RAddr),
        .RVld      (mem_rvld),
        .RData     (mem_rdata),
        .inst_vld  (inst_vld),
        .inst_rdy  (inst_rdy),
        .inst_data (inst_data),
        .inst_pc   (inst_pc)
    );

    always #5 clk = ~clk;

    // memory contents: words 0..3 hold 0x11..0x44, everything else tags its own address
    function automatic logic [31:0] memword(input logic [31:0] wa);
        if (wa < 32'd4) return (wa + 32'd1) * 32'h11;
        return 32'hD000_0000 | wa;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_pc_log.delete();
        pop_data_log.delete();
        pop_cyc_log.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0; start = 1'b0; halt = 1'b0; redir_vld = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_pops(input int want, input int budget, input string name);
        int n = 0;
        while (pop_pc_log.size() < want && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(pop_pc_log.size() >= want), 32'd1);
    endtask

    // Memory responder: samples a request when idle, answers mem_lat cycles later.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mem_rvld <= 1'b0;
        if (mem_cnt != 0) begin
            if (mem_cnt == 1) begin
                mem_rvld  <= 1'b1;
                mem_rdata <= memword(mem_addr);
            end
            mem_cnt <= mem_cnt - 1;
        end else if (RRdy === 1'b1 && !mem_rvld) begin
            req_log.push_back(RAddr);
            mem_addr <= RAddr;
            if (mem_lat <= 1) begin
                mem_rvld  <= 1'b1;
                mem_rdata <= memword(RAddr);
            end else begin
                mem_cnt <= mem_lat - 1;
            end
        end
    end

    // Stream model and per-cycle compare: decode must see pc, pc+4, ... from the
    // latest start/redirect target, each with the memory word at that address.
    initial begin : compare
        bit          known = 1'b0;
        bit          chk_reset = 1'b0;
        bit          chk_empty = 1'b0;
        bit          hold = 1'b0;
        logic [31:0] hold_addr = '0;
        forever begin
            @(negedge clk);
            if (chk_reset) begin
                check("rst_RRdy", RRdy, 0);
                check("rst_RAddr", RAddr, 0);
                check("rst_inst_vld", inst_vld, 0);
                check("rst_inst_data", inst_data, 0);
                check("rst_inst_pc", inst_pc, 0);
                chk_reset = 1'b0;
            end
            if (!rstn) begin
                known     = 1'b1;
                mode      = M_IDLE;
                chk_reset = 1'b1;
                chk_empty = 1'b0;
                hold      = 1'b0;
            end else if (known) begin
                if (chk_empty) check("flush_inst_vld", inst_vld, 0);
                chk_empty = 1'b0;
                if (hold && RRdy === 1'b1) check("raddr_stable", RAddr, hold_addr);
                hold      = (RRdy === 1'b1) && !mem_rvld;
                hold_addr = RAddr;
                case (mode)
                    M_IDLE: begin
                        check("idle_RRdy", RRdy, 0);
                        check("idle_inst_vld", inst_vld, 0);
                        if (start) begin
                            mode   = M_RUN;
                            exp_pc = RESET_PC;
                        end
                    end
                    default: begin
                        if (mode == M_RUN && redir_vld) begin
                            exp_pc    = redir_pc & 32'hFFFF_FFFC;
                            chk_empty = 1'b1;
                        end else if (inst_vld === 1'b1 && inst_rdy) begin
                            check("pop_pc", inst_pc, exp_pc);
                            check("pop_data", inst_data, memword(exp_pc >> 2));
                            pop_pc_log.push_back(inst_pc);
                            pop_data_log.push_back(inst_data);
                            pop_cyc_log.push_back(cyc);
                            exp_pc = exp_pc + 32'd4;
                        end
                        if (mode == M_RUN && halt) mode = M_HALT;
                    end
                endcase
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        int rq;

        // sequential stream at full throughput
        do_reset();
        clear_logs();
        inst_rdy = 1'b1;
        pulse_start();
        wait_pops(4, 40, "t1_timeout");
        for (int i = 0; i < 4; i++) begin
            check("t1_pc", pop_pc_log[i], 32'(i * 4));
            check("t1_data", pop_data_log[i], 32'(32'h11 * (i + 1)));
            check("t1_raddr", req_log[i], 32'(i));
            if (i > 0) check("t1_spacing", 32'(pop_cyc_log[i] - pop_cyc_log[i-1]), 32'd2);
        end

        // back-pressure: buffer fills, bus goes quiet, then resumes without loss
        do_reset();
        clear_logs();
        inst_rdy = 1'b0;
        pulse_start();
        repeat (10) tick();
        check("t2_inst_vld", inst_vld, 1);
        check("t2_RRdy", RRdy, 0);
        check("t2_RAddr", RAddr, 32'd2);
        check("t2_head_pc", inst_pc, 32'd0);
        check("t2_reqs", 32'(req_log.size()), 32'd2);
        inst_rdy = 1'b1;
        wait_pops(4, 40, "t2_timeout");
        check("t2_pc0", pop_pc_log[0], 32'd0);
        check("t2_pc1", pop_pc_log[1], 32'd4);
        check("t2_pc2", pop_pc_log[2], 32'd8);
        check("t2_pc3", pop_pc_log[3], 32'd12);

        // redirect while the pc 4 request is in flight
        do_reset();
        clear_logs();
        inst_rdy = 1'b1;
        pulse_start();
        n = 0;
        while (!(RRdy === 1'b1 && RAddr == 32'd1) && n < 40) begin tick(); n++; end
        check("t3_wait", 32'(n < 40), 32'd1);
        clear_logs();
        redir_pc  = 32'h400;
        redir_vld = 1'b1;
        tick();
        redir_vld = 1'b0;
        wait_pops(2, 40, "t3_timeout");
        check("t3_pc", pop_pc_log[0], 32'h400);
        check("t3_data", pop_data_log[0], 32'hD000_0100);
        check("t3_pc_next", pop_pc_log[1], 32'h404);
        check("t3_req", req_log[1], 32'h100);

        // redirect in the same cycle as the pc 8 response, unaligned target
        do_reset();
        clear_logs();
        inst_rdy = 1'b1;
        pulse_start();
        n = 0;
        while (!(mem_rvld && RAddr == 32'd2) && n < 40) begin tick(); n++; end
        check("t4_wait", 32'(n < 40), 32'd1);
        clear_logs();
        redir_pc  = 32'h403;
        redir_vld = 1'b1;
        tick();
        redir_vld = 1'b0;
        wait_pops(2, 40, "t4_timeout");
        check("t4_pc", pop_pc_log[0], 32'h400);
        check("t4_data", pop_data_log[0], 32'hD000_0100);
        check("t4_req", req_log[0], 32'h100);

        // halt with the pc 12 request in flight
        do_reset();
        clear_logs();
        inst_rdy = 1'b1;
        pulse_start();
        n = 0;
        while (!(RRdy === 1'b1 && RAddr == 32'd3 && !mem_rvld) && n < 40) begin tick(); n++; end
        check("t5_wait", 32'(n < 40), 32'd1);
        rq = req_log.size();
        pop_pc_log.delete();
        pop_data_log.delete();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        wait_pops(2, 20, "t5_timeout");
        repeat (4) tick();
        start     = 1'b1;
        redir_pc  = 32'h800;
        redir_vld = 1'b1;
        tick();
        start     = 1'b0;
        redir_vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("t5_RRdy", RRdy, 0);
            tick();
        end
        check("t5_reqs", 32'(req_log.size()), 32'(rq + 1));
        check("t5_pops", 32'(pop_pc_log.size()), 32'd2);
        check("t5_last_pc", pop_pc_log[1], 32'd12);
        check("t5_last_data", pop_data_log[1], 32'h44);
        check("t5_inst_vld", inst_vld, 0);

        // reset pulse mid-fetch with one word buffered
        do_reset();
        clear_logs();
        inst_rdy = 1'b0;
        pulse_start();
        n = 0;
        while (!(RRdy === 1'b1 && RAddr == 32'd1 && inst_vld === 1'b1) && n < 40) begin tick(); n++; end
        check("t6_wait", 32'(n < 40), 32'd1);
        rstn = 1'b0;
        tick();
        check("t6_inst_vld", inst_vld, 0);
        check("t6_RRdy", RRdy, 0);
        check("t6_RAddr", RAddr, 0);
        rstn = 1'b1;
        repeat (4) tick();
        check("t6_late_rvld", inst_vld, 0);
        clear_logs();
        inst_rdy = 1'b1;
        pulse_start();
        wait_pops(2, 40, "t6_timeout");
        check("t6_pc0", pop_pc_log[0], 32'd0);
        check("t6_pc1", pop_pc_log[1], 32'd4);

        // longer memory latency
        do_reset();
        mem_lat = 3;
        clear_logs();
        inst_rdy = 1'b1;
        pulse_start();
        wait_pops(4, 80, "t7_timeout");
        check("t7_pc3", pop_pc_log[3], 32'd12);
        check("t7_data3", pop_data_log[3], 32'h44);
        check("t7_reqs", 32'(req_log[3]), 32'd3);
        inst_rdy = 1'b0;
        repeat (12) tick();
        mem_lat = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
